csi_capture_ctrl: RTL
=====================

# csi_capture_ctrl

Capture controller between the LTS extractor's output stream and the DMA stream. Arms on software command (single-shot or continuous with frame decimation), buffers one complete two-LTS frame, validates its length, then replays it to the DMA with an optional header word. Aborts malformed or stalled frames and pulses a reset back to the extractor so it re-synchronises on the next packet.

## Interface
- FRAME_LEN, 128: samples per valid LTS frame (two 64-sample LTS).
- TIMEOUT_CYCLES, 4096: max clock cycles between accepted samples inside a frame.
- clk_in  input  1  system clock; all logic on rising edge.
- rst_in  input  1  synchronous, active-high reset.
- arm_in  input  1  single-cycle pulse; arms one capture.
- continuous_in  input  1  level; 1 = capture repeatedly without re-arming.
- decim_in  input  8  in continuous mode, capture 1 of every decim_in+1 frames.
- lts_axis_tvalid  input  1  extractor sample valid.
- lts_axis_tlast  input  1  last sample of extractor frame.
- lts_axis_tdata  input  32  {I[15:0], Q[15:0]}.
- lts_axis_tready  output  1  always 1 out of reset; the extractor is never back-pressured.
- dma_axis_tvalid / dma_axis_tlast  output  1 / 1  DMA stream valid / last.
- dma_axis_tdata  output  32  header or sample.
- dma_axis_tready  input  1  DMA ready.
- extractor_rst_out  output  1  one-cycle pulse requesting extractor resync.
- busy_out  output  1  high in any state except IDLE.
- frames_captured_out  output  16  count of frames fully sent to DMA, wraps.
- frames_dropped_out  output  16  count of aborted/discarded frames, wraps.

## Operation
- Frame boundary tracking: `frame_start` is the first valid beat after reset or after a beat with tlast. Capture begins only at a frame_start; arming mid-frame waits for the next frame.
- States:
  - IDLE: armed = arm_in pulse seen or continuous_in = 1. At a frame_start beat:
    - if armed and skip_cnt == 0, go to CAPTURE and write that beat at addr 0;
    - if armed and skip_cnt != 0, go to SKIP and decrement skip_cnt.
  - SKIP: consume beats until tlast, then go to IDLE. Skipped frames are not counted as dropped.
  - CAPTURE: write each valid beat to the buffer at addr = count.
    - tlast with count+1 == FRAME_LEN: go to HEADER (or DRAIN if the header is compiled out).
    - tlast early, or FRAME_LEN beats without tlast: abort.
    - TIMEOUT_CYCLES cycles without a valid beat: abort.
  - Abort: frames_dropped +1, one-cycle extractor_rst_out, go to IDLE. After an overlong abort, the remaining beats up to the next tlast are discarded (no frame_start until then).
  - HEADER: present {16'hC51D, frames_captured[15:0]}; advance on handshake.
  - DRAIN: present buffer[0..FRAME_LEN-1]; tlast on the last beat. On its handshake: frames_captured +1; clear the single-shot armed flag; reload skip_cnt = decim_in (continuous) or 0; go to IDLE.
- Frames arriving during HEADER/DRAIN are accepted (tready = 1), discarded, and counted dropped at their tlast only when armed. This includes frames that would have been captured (continuous, or arm_in received during the drain).
- arm_in during CAPTURE/HEADER/DRAIN: latched, and applies at the next IDLE.
- continuous_in falling mid-frame: the current frame completes normally; no further captures without arm_in.
- Buffer: FRAME_LEN x 32 single-port-write / single-port-read RAM with 1-cycle read latency. Reads are prefetched so DMA throughput is one beat per cycle while dma_axis_tready = 1.

## Timing
- Reset values: every output 0 except lts_axis_tready = 1 from the first cycle after reset. State IDLE, armed = 0, skip_cnt = 0, counters 0.
- First DMA beat is valid the cycle after the accepted final-sample beat of a good frame.
- AXIS rules on the DMA side: tdata and tlast are held stable while tvalid && !tready; tvalid never drops without a handshake.
- Timeout counter resets on every accepted beat in CAPTURE. Abort occurs on the cycle the count reaches TIMEOUT_CYCLES. extractor_rst_out is asserted the following cycle, for exactly one cycle.
- Reset mid-DRAIN: tvalid drops the next cycle. The partial frame is not counted.
- Simultaneous tlast and timeout expiry: tlast wins.

## Configuration
- CSI_CAPTURE_HEADER_EN defined: the HEADER state exists; a DMA packet is FRAME_LEN+1 beats.
- CSI_CAPTURE_HEADER_EN undefined: HEADER is removed; a DMA packet is FRAME_LEN beats. Counters are unchanged.

## Test plan
- arm_in pulse, one good 128-beat frame, dma_axis_tready = 1 → 129 beats: 0xC51D0000, then samples 0..127; tlast on beat 129; frames_captured = 1; busy_out low afterwards.
- continuous_in = 1, decim_in = 2, 9 good frames → frames 1, 4 and 7 are sent; frames_dropped = 0.
- arm_in, frame with tlast at beat 100 → no DMA output; frames_dropped = 1; extractor_rst_out high for exactly 1 cycle.
- arm_in, 50 beats then silence → abort at 4096 idle cycles; extractor_rst_out pulse; next good frame is captured after arm_in.
- Random dma_axis_tready (50%) during drain → data/tlast stable under stall; all 129 beats in order.
- Second frame arriving during a stalled drain in continuous mode → discarded; frames_dropped = 1; first packet intact.

Source files
------------

// File: rtl/csi_capture_ctrl_if.sv
// csi_capture_ctrl_if: 32-bit AXI4-Stream link (valid/ready/last/data) with source and sink views
interface csi_capture_ctrl_if;
    logic        tvalid;
    logic        tready;
    logic        tlast;
    logic [31:0] tdata;
    modport master (output tvalid, output tlast, output tdata, input tready);
    modport slave  (input tvalid, input tlast, input tdata, output tready);
endinterface

// File: rtl/csi_capture_ctrl.sv
// csi_capture_ctrl: buffers one two-LTS frame from the extractor, validates it and replays it to DMA; define CSI_CAPTURE_HEADER_EN to prepend a header word
module csi_capture_ctrl #(
    parameter int FRAME_LEN      = 128,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic                      arm_in,
    input  logic                      continuous_in,
    input  logic [7:0]                decim_in,
    csi_capture_ctrl_if.slave         lts_axis,
    csi_capture_ctrl_if.master        dma_axis,
    output logic                      extractor_rst_out,
    output logic                      busy_out,
    output logic [15:0]               frames_captured_out,
    output logic [15:0]               frames_dropped_out
);
    localparam int AW = $clog2(FRAME_LEN);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [AW-1:0] LAST = AW'(FRAME_LEN - 1);

    typedef enum logic [2:0] {IDLE, SKIP, CAPTURE, HEADER, DRAIN} state_t;
`ifdef CSI_CAPTURE_HEADER_EN
    localparam state_t FIRST_OUT = HEADER;
`else
    localparam state_t FIRST_OUT = DRAIN;
`endif

    state_t        r_state, w_next;
    logic          r_in_frame, r_armed, r_pend, r_disc, r_rst;
    logic [7:0]    r_skip;
    logic [AW-1:0] r_cnt, r_idx, w_raddr;
    logic [TW-1:0] r_tmo;
    logic [15:0]   r_cap, r_drop;
    logic [31:0]   r_mem [FRAME_LEN];
    logic [31:0]   r_rd, w_tdata;
    logic          w_tvalid, w_tlast, w_hs;
    logic          w_beat, w_start, w_last, w_out, w_busy_cap, w_go, w_cap_go, w_skip_go;
    logic          w_good, w_tmo, w_abort, w_done, w_disc_drop, w_wr;

    assign w_beat      = lts_axis.tvalid;
    assign w_start     = w_beat && !r_in_frame;
    assign w_last      = w_beat && lts_axis.tlast;
    assign w_out       = (r_state == HEADER) || (r_state == DRAIN);
    assign w_busy_cap  = w_out || (r_state == CAPTURE);
    assign w_go        = (r_state == IDLE) && w_start && (continuous_in || r_armed);
    assign w_cap_go    = w_go && (r_skip == '0);
    assign w_skip_go   = w_go && (r_skip != '0);
    assign w_good      = (r_state == CAPTURE) && w_last && (r_cnt == LAST);
    // a beat in the same cycle always beats the timeout, so tlast wins a tie
    assign w_tmo       = (r_state == CAPTURE) && !w_beat && (r_tmo == TW'(TIMEOUT_CYCLES - 1));
    assign w_abort     = (w_cap_go && lts_axis.tlast) || w_tmo ||
                         ((r_state == CAPTURE) && w_beat && (lts_axis.tlast != (r_cnt == LAST)));
    assign w_hs        = w_tvalid && dma_axis.tready;
    assign w_done      = (r_state == DRAIN) && w_hs && (r_idx == LAST);
    // frames seen while replaying are thrown away; they count as dropped only if they would have been wanted
    assign w_disc_drop = w_last && (r_disc || (w_out && w_start)) &&
                         (continuous_in || (w_out ? r_pend : r_armed));
    assign w_wr        = w_beat && ((r_state == CAPTURE) || w_cap_go);

    assign lts_axis.tready     = 1'b1;
    assign dma_axis.tvalid     = w_tvalid;
    assign dma_axis.tlast      = w_tlast;
    assign dma_axis.tdata      = w_tdata;
    assign extractor_rst_out   = r_rst;
    assign busy_out            = r_state != IDLE;
    assign frames_captured_out = r_cap;
    assign frames_dropped_out  = r_drop;

    // state register
    always_ff @(posedge clk_in) begin
        if (rst_in) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = (w_cap_go && !lts_axis.tlast) ? CAPTURE :
                              (w_skip_go && !lts_axis.tlast) ? SKIP : IDLE;
            SKIP:    w_next = w_last ? IDLE : SKIP;
            CAPTURE: w_next = w_good ? FIRST_OUT : w_abort ? IDLE : CAPTURE;
            HEADER:  w_next = w_hs ? DRAIN : HEADER;
            DRAIN:   w_next = w_done ? IDLE : DRAIN;
            default: w_next = IDLE;
        endcase
    end

    // DMA outputs; the read address runs one ahead on each handshake so the RAM keeps pace
    always_comb begin
        w_tvalid = w_out;
        w_tlast  = (r_state == DRAIN) && (r_idx == LAST);
        w_tdata  = (r_state == HEADER) ? {16'hC51D, r_cap} : (r_state == DRAIN) ? r_rd : '0;
        w_raddr  = ((r_state == DRAIN) && w_hs && (r_idx != LAST)) ? r_idx + 1'b1 : r_idx;
    end

    // frame tracking, arming, decimation, timeout and statistics
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_in_frame <= 1'b0;
            r_armed    <= 1'b0;
            r_pend     <= 1'b0;
            r_disc     <= 1'b0;
            r_rst      <= 1'b0;
            r_skip     <= '0;
            r_cnt      <= '0;
            r_idx      <= '0;
            r_tmo      <= '0;
            r_cap      <= '0;
            r_drop     <= '0;
        end else begin
            r_rst      <= w_abort;
            r_in_frame <= w_tmo ? 1'b0 : w_beat ? !lts_axis.tlast : r_in_frame;
            r_armed    <= (w_done || w_abort) ? (r_pend || arm_in || (w_abort && r_armed)) :
                          (r_armed || (arm_in && !w_busy_cap));
            r_pend     <= !(w_done || w_abort) && (r_pend || (arm_in && w_busy_cap));
            r_disc     <= w_last ? 1'b0 : (w_out && w_start) ? 1'b1 : r_disc;
            r_skip     <= w_done ? (continuous_in ? decim_in : 8'd0) :
                          w_skip_go ? r_skip - 1'b1 : r_skip;
            r_cnt      <= (w_next != CAPTURE) ? '0 : w_beat ? r_cnt + 1'b1 : r_cnt;
            r_idx      <= ((r_state == DRAIN) && !w_done) ? w_raddr : '0;
            r_tmo      <= ((r_state == CAPTURE) && !w_beat) ? r_tmo + 1'b1 : '0;
            r_cap      <= r_cap + 16'(w_done);
            r_drop     <= r_drop + 16'(w_abort) + 16'(w_disc_drop);
        end
    end

    // frame buffer: one write port, one registered read port
    always_ff @(posedge clk_in) begin
        if (w_wr) r_mem[r_cnt] <= lts_axis.tdata;
        r_rd <= r_mem[w_raddr];
    end
endmodule
